// File: rtl/sam_mem_pkg.sv
// Shared types for the sam_rv32i memory arbiter.
// FSM states, port ownership and default widths.
package sam_mem_pkg;

  localparam int SAM_AW  = 32;
  localparam int SAM_DW  = 32;
  localparam int SAM_BEW = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } owner_e;

endpackage

// File: rtl/sam_arb_pick.sv
// Grant decision between fetch and data ports.
// Data wins unless fetch has waited MAX_DSTREAK data grants.
module sam_arb_pick #(
  parameter int MAX_DSTREAK = 4,
  parameter int SW          = $clog2(MAX_DSTREAK + 1)
) (
  input  logic          if_req_i,
  input  logic          d_req_i,
  input  logic [SW-1:0] dstreak_i,
  output logic          grant_if_o,
  output logic          grant_d_o
);

  logic at_max;

  assign at_max     = (dstreak_i == SW'(MAX_DSTREAK));
  assign grant_d_o  = d_req_i & ~(if_req_i & at_max);
  assign grant_if_o = if_req_i & ~grant_d_o;

endmodule

// File: rtl/sam_mem_arbiter.sv
// Single-port memory arbiter for IF and MEM stages.
// One access in flight; data priority with fetch anti-starvation.
module sam_mem_arbiter
  import sam_mem_pkg::*;
#(
  parameter int AW          = SAM_AW,
  parameter int DW          = SAM_DW,
  parameter int MEM_LAT     = 2,
  parameter int MAX_DSTREAK = 4
) (
  input  logic          clk,
  input  logic          RN,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic [3:0]    d_be,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [3:0]    mem_be,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall_if,
  output logic          stall_mem
);

  localparam int CW = $clog2(MEM_LAT + 1);
  localparam int SW = $clog2(MAX_DSTREAK + 1);

  state_e        state_q;
  owner_e        owner_q;
  logic [CW-1:0] cnt_q;
  logic [SW-1:0] dstreak_q;
  logic [SW-1:0] dstreak_d;
  logic          if_ack_q;
  logic          d_ack_q;
  logic [DW-1:0] if_rdata_q;
  logic [DW-1:0] d_rdata_q;
  logic          mem_en_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic [3:0]    mem_be_q;
  logic          grant_if;
  logic          grant_d;

  sam_arb_pick #(
    .MAX_DSTREAK (MAX_DSTREAK),
    .SW          (SW)
  ) u_pick (
    .if_req_i   (if_req),
    .d_req_i    (d_req),
    .dstreak_i  (dstreak_q),
    .grant_if_o (grant_if),
    .grant_d_o  (grant_d)
  );

  // Streak of data grants that overtook a pending fetch.
  always_comb begin
    dstreak_d = dstreak_q;
    if (grant_d) begin
      if (!if_req)
        dstreak_d = '0;
      else if (dstreak_q != SW'(MAX_DSTREAK))
        dstreak_d = dstreak_q + SW'(1);
    end else if (grant_if) begin
      dstreak_d = '0;
    end
  end

  // Access FSM with latency counter and registered outputs.
  always_ff @(posedge clk or posedge RN) begin
    if (RN) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      cnt_q       <= '0;
      dstreak_q   <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
    end else begin
      mem_en_q <= 1'b0;
      if_ack_q <= 1'b0;
      d_ack_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (grant_if | grant_d) begin
            state_q   <= ST_ISSUE;
            mem_en_q  <= 1'b1;
            dstreak_q <= dstreak_d;
            if (grant_d) begin
              owner_q     <= OWN_D;
              mem_we_q    <= d_we;
              mem_addr_q  <= d_addr;
              mem_wdata_q <= d_wdata;
              mem_be_q    <= d_be;
            end else begin
              owner_q     <= OWN_IF;
              mem_we_q    <= 1'b0;
              mem_addr_q  <= if_addr;
              mem_wdata_q <= '0;
              mem_be_q    <= 4'hF;
            end
          end
        end
        ST_ISSUE: begin
          cnt_q   <= CW'(MEM_LAT);
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= ST_RESP;
            if (owner_q == OWN_IF) begin
              if_rdata_q <= mem_rdata;
              if_ack_q   <= 1'b1;
            end else begin
              if (!mem_we_q)
                d_rdata_q <= mem_rdata;
              d_ack_q <= 1'b1;
            end
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign stall_if  = if_req & ~if_ack_q;
  assign stall_mem = d_req & ~d_ack_q;

endmodule
